reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with a per-register busy
// scoreboard, optional write-to-read forwarding, a background clear sweep
// and a registered debug mirror of one register.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   rd_addr / rd_data   NUM_RD packed read indices / combinational read data
//   rd_busy             scoreboard busy flag per read port
//   issue_en, issue_rd  mark a destination register as having a pending write
//   issue_rdy           high while issue and write-back are being accepted
//   wb_en, wb_addr,
//   wb_data             write-back port (also clears the busy bit)
//   clr_req, clr_busy   start a clear sweep / sweep in progress
//   dbg_out             registered copy of register DBG_IDX
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int DBG_IDX    = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           issue_rdy,
    input  logic                           wb_en,
    input  logic [ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic [DATA_WIDTH-1:0]          dbg_out
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DBG_ADDR = ADDR_WIDTH'(DBG_IDX);
    localparam bit                    BYP_EN   = (BYPASS != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic                    wb_write;
    logic                    iss_set;
    logic [DATA_WIDTH-1:0]   dbg_next;

    assign issue_rdy = (state == IDLE);
    assign clr_busy  = (state == CLEAR);

    // Register 0 is never written or marked busy, so its storage stays zero
    // from reset and reads of it need no special casing.
    assign wb_write = wb_en & issue_rdy & (wb_addr != '0);
    assign iss_set  = issue_en & issue_rdy & (issue_rd != '0);

    // dbg_out tracks the value the debug register holds after this edge,
    // so a write to it shows up on dbg_out without an extra cycle of lag.
    always_comb begin
        dbg_next = regs[DBG_IDX];
        if (state == CLEAR && ptr == DBG_ADDR) begin
            dbg_next = '0;
        end else if (wb_write && wb_addr == DBG_ADDR) begin
            dbg_next = wb_data;
        end
    end

    // FSM, storage and scoreboard share one block so the sweep and the
    // normal write path can never both drive the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            busy    <= '0;
            dbg_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            dbg_out <= dbg_next;
            case (state)
                IDLE: begin
                    if (wb_write) begin
                        regs[wb_addr] <= wb_data;
                        busy[wb_addr] <= 1'b0;
                    end
                    // Issued after the write-back clear so a same-index
                    // issue wins and the register stays busy.
                    if (iss_set) begin
                        busy[issue_rd] <= 1'b1;
                    end
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= ADDR_WIDTH'(1);
                    end
                end
                CLEAR: begin
                    regs[ptr] <= '0;
                    busy[ptr] <= 1'b0;
                    ptr       <= ptr + ADDR_WIDTH'(1);
                    if (ptr == LAST_IDX) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read ports. Forwarding only fires on an accepted write-back, which is
    // impossible during a sweep and never targets register 0.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  fwd;

        assign ra  = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign fwd = BYP_EN && wb_write && (wb_addr == ra);

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = fwd ? wb_data : regs[ra];
        assign rd_busy[k] = fwd ? 1'b0 : busy[ra];
    end

endmodule
